// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory-side bus controller: command encodings,
// controller state encoding and default MMIO addresses.
package mem_bus_ctrl_pkg;

  // Command encodings shared with the CPU-side FSM.
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RESP    = 2'b10
  } state_e;

endpackage

// File: rtl/mem_bus_ctrl_decode.sv
// Combinational address decode: classifies a READ/WRITE request as RAM,
// LED register, switch port or unmapped. NONE and the reserved code decode to nothing.
module mem_addr_decode
  import mem_bus_ctrl_pkg::*;
#(
  parameter logic [8:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [8:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic [1:0] mem_cmd,
  input  logic [8:0] mem_addr,
  output logic       is_ram,
  output logic       is_led,
  output logic       is_sw,
  output logic       is_err
);

  logic is_rd;
  logic is_wr;

  assign is_rd  = (mem_cmd == MEM_READ);
  assign is_wr  = (mem_cmd == MEM_WRITE);

  // The LED register is write-only and the switch port read-only; the wrong
  // direction falls through to is_err.
  assign is_ram = (is_rd || is_wr) && !mem_addr[8];
  assign is_led = is_wr && (mem_addr == LED_ADDR);
  assign is_sw  = is_rd && (mem_addr == SW_ADDR);
  assign is_err = (is_rd || is_wr) && !(is_ram || is_led || is_sw);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: fronts a 256x16 synchronous RAM and two MMIO
// locations. Define MEM_BUS_CTRL_SW_SYNC_EN to put a 2-flop synchronizer on sw.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [8:0]  LED_ADDR = LED_ADDR_DEF,
  parameter logic [8:0]  SW_ADDR  = SW_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [15:0] ram_rdata,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        bus_err
);

  state_e      state, state_nxt;
  logic [2:0]  lat_cnt, lat_cnt_nxt;
  logic [15:0] read_data_nxt;
  logic [7:0]  led_nxt;
  logic        bus_err_nxt;
  logic        ram_re_c, ram_we_c;
  logic        is_ram, is_led, is_sw, is_err;
  logic [7:0]  sw_sel;

  mem_addr_decode #(
    .LED_ADDR (LED_ADDR),
    .SW_ADDR  (SW_ADDR)
  ) u_decode (
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .is_ram   (is_ram),
    .is_led   (is_led),
    .is_sw    (is_sw),
    .is_err   (is_err)
  );

`ifdef MEM_BUS_CTRL_SW_SYNC_EN
  logic [7:0] sw_meta, sw_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  assign sw_sel = sw_sync;
`else
  assign sw_sel = sw;
`endif

  assign ram_addr  = mem_addr[7:0];
  assign ram_wdata = write_data;
  assign mem_ready = (state == RESP);
  // Strobes are decoded from IDLE, which reset forces; gating keeps them low
  // while reset is held even if a request is still presented.
  assign ram_re    = ram_re_c & reset;
  assign ram_we    = ram_we_c & reset;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    read_data_nxt = read_data;
    led_nxt       = led;
    bus_err_nxt   = bus_err;
    ram_re_c      = 1'b0;
    ram_we_c      = 1'b0;

    case (state)
      IDLE: begin
        if (mem_cmd == MEM_RSVD) begin
          bus_err_nxt = 1'b1;
        end else if (is_ram && (mem_cmd == MEM_READ)) begin
          ram_re_c    = 1'b1;
          lat_cnt_nxt = 3'(RD_LAT);
          state_nxt   = RD_WAIT;
        end else if (is_ram) begin
          ram_we_c  = 1'b1;
          state_nxt = RESP;
        end else if (is_sw) begin
          read_data_nxt = {8'h00, sw_sel};
          state_nxt     = RESP;
        end else if (is_led) begin
          led_nxt   = write_data[7:0];
          state_nxt = RESP;
        end else if (is_err) begin
          bus_err_nxt = 1'b1;
          if (mem_cmd == MEM_READ) read_data_nxt = '0;
          state_nxt = RESP;
        end
      end

      RD_WAIT: begin
        lat_cnt_nxt = lat_cnt - 3'd1;
        // Count reaches 1 in the cycle the RAM presents data.
        if (lat_cnt <= 3'd1) begin
          lat_cnt_nxt   = '0;
          read_data_nxt = ram_rdata;
          state_nxt     = RESP;
        end
      end

      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      read_data <= '0;
      led       <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_cnt_nxt;
      read_data <= read_data_nxt;
      led       <= led_nxt;
      bus_err   <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: three instances (RD_LAT 1, 3, 4), one
// active at a time, compared every cycle against a transaction-level model.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  localparam int N_LANE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  int          sel;

  logic [1:0]  cmd_l      [N_LANE];
  logic [15:0] rd_l       [N_LANE];
  logic        ready_l    [N_LANE];
  logic [7:0]  raddr_l    [N_LANE];
  logic [15:0] wdata_l    [N_LANE];
  logic        we_l       [N_LANE];
  logic        re_l       [N_LANE];
  logic [15:0] ram_in_l   [N_LANE];
  logic [7:0]  led_l      [N_LANE];
  logic        err_l      [N_LANE];

  always_comb for (int i = 0; i < N_LANE; i++) cmd_l[i] = (sel == i) ? mem_cmd : MEM_NONE;

  mem_bus_ctrl #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .mem_cmd(cmd_l[0]), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(rd_l[0]), .mem_ready(ready_l[0]), .ram_addr(raddr_l[0]), .ram_wdata(wdata_l[0]),
    .ram_we(we_l[0]), .ram_re(re_l[0]), .ram_rdata(ram_in_l[0]), .sw(sw), .led(led_l[0]),
    .bus_err(err_l[0]));
  mem_bus_ctrl #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .mem_cmd(cmd_l[1]), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(rd_l[1]), .mem_ready(ready_l[1]), .ram_addr(raddr_l[1]), .ram_wdata(wdata_l[1]),
    .ram_we(we_l[1]), .ram_re(re_l[1]), .ram_rdata(ram_in_l[1]), .sw(sw), .led(led_l[1]),
    .bus_err(err_l[1]));
  mem_bus_ctrl #(.RD_LAT(4)) u_lat4 (
    .clk(clk), .reset(reset), .mem_cmd(cmd_l[2]), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(rd_l[2]), .mem_ready(ready_l[2]), .ram_addr(raddr_l[2]), .ram_wdata(wdata_l[2]),
    .ram_we(we_l[2]), .ram_re(re_l[2]), .ram_rdata(ram_in_l[2]), .sw(sw), .led(led_l[2]),
    .bus_err(err_l[2]));

  function automatic int lat_of(input int lane);
    case (lane)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] fill(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A5A;
  endfunction

  // Active-lane view of the DUT outputs.
  logic [15:0] r_read_data, r_ram_wdata;
  logic [7:0]  r_ram_addr, r_led;
  logic        r_ready, r_ram_we, r_ram_re, r_bus_err;
  assign r_read_data = rd_l[sel];
  assign r_ready     = ready_l[sel];
  assign r_ram_addr  = raddr_l[sel];
  assign r_ram_wdata = wdata_l[sel];
  assign r_ram_we    = we_l[sel];
  assign r_ram_re    = re_l[sel];
  assign r_led       = led_l[sel];
  assign r_bus_err   = err_l[sel];

  // Environment RAM: unwritten words read as fill(addr); data appears exactly
  // RD_LAT cycles after ram_re and is random junk otherwise.
  logic [15:0] env_mem [256];
  bit          written [256];
  logic [15:0] pipe [8];
  always @(posedge clk) begin
    if (r_ram_we) begin
      env_mem[r_ram_addr] <= r_ram_wdata;
      written[r_ram_addr] <= 1'b1;
    end
    pipe[0] <= r_ram_re ? (written[r_ram_addr] ? env_mem[r_ram_addr] : fill(r_ram_addr))
                        : 16'($urandom);
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_in_l[0] = pipe[0];
  assign ram_in_l[1] = pipe[2];
  assign ram_in_l[2] = pipe[3];

  // Reference model state.
  logic [15:0] model_mem [256];
  logic [15:0] exp_rd  [N_LANE];
  logic [7:0]  exp_led [N_LANE];
  logic        exp_err [N_LANE];
  logic        exp_ready, exp_re, exp_we;
  logic [7:0]  sw_model;

  int n_pass = 0, n_total = 0;
  int cyc = 0, issue_cyc = 0, ready_cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_ready", r_ready, exp_ready);
      check("ram_re", r_ram_re, exp_re);
      check("ram_we", r_ram_we, exp_we);
      check("read_data", r_read_data, exp_rd[sel]);
      check("led", r_led, exp_led[sel]);
      check("bus_err", r_bus_err, exp_err[sel]);
      check("ram_addr", r_ram_addr, mem_addr[7:0]);
      check("ram_wdata", r_ram_wdata, write_data);
      if (r_ready) ready_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_cmd = MEM_NONE;
    repeat (n) step();
  endtask

  task automatic set_sw(input logic [7:0] v);
    sw       = v;
    sw_model = v;
    idle(3);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_LANE; i++) begin
      exp_rd[i]  = '0;
      exp_led[i] = '0;
      exp_err[i] = 1'b0;
    end
    exp_ready = 1'b0;
    exp_re    = 1'b0;
    exp_we    = 1'b0;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the next IDLE
  // cycle with the command still presented (so a following call is back-to-back).
  task automatic do_access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bit rd, wr, ram, led_hit, sw_hit;
    int nwait;
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    issue_cyc  = cyc;
    rd      = (cmd == MEM_READ);
    wr      = (cmd == MEM_WRITE);
    ram     = (rd || wr) && !addr[8];
    led_hit = wr && (addr == LED_ADDR_DEF);
    sw_hit  = rd && (addr == SW_ADDR_DEF);
    exp_re    = ram && rd;
    exp_we    = ram && wr;
    exp_ready = 1'b0;
    if (!rd && !wr) begin
      step();
      if (cmd == MEM_RSVD) exp_err[sel] = 1'b1;
      mem_cmd = MEM_NONE;
      return;
    end
    nwait = (ram && rd) ? lat_of(sel) : 0;
    step();
    exp_re = 1'b0;
    exp_we = 1'b0;
    if (ram && wr) model_mem[addr[7:0]] = wd;
    repeat (nwait) step();
    exp_ready = 1'b1;
    if (led_hit) exp_led[sel] = wd[7:0];
    if (!(ram || led_hit || sw_hit)) exp_err[sel] = 1'b1;
    if (rd) exp_rd[sel] = ram ? model_mem[addr[7:0]] : (sw_hit ? {8'h00, sw_model} : 16'h0000);
    step();
    exp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    reset = 1'b1; mem_cmd = MEM_NONE; mem_addr = '0; write_data = '0; sw = '0; sw_model = '0;
    sel = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = fill(8'(i));
    model_reset();
    #3 reset = 1'b0;
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b1;
    idle(3);
    check("reset_read_data", r_read_data, 16'h0000);
    check("reset_led", r_led, 8'h00);
    check("reset_bus_err", r_bus_err, 1'b0);

    // RD_LAT=1: RAM write then read.
    sel = 0;
    do_access(MEM_WRITE, 9'h005, 16'hBEEF);
    check("wr_ready_cycle", ready_cyc - issue_cyc, 1);
    do_access(MEM_READ, 9'h005, 16'h0000);
    check("rd1_ready_cycle", ready_cyc - issue_cyc, 2);
    check("rd1_data", r_read_data, 16'hBEEF);
    idle(1);

    // RD_LAT=3 read, data held afterwards.
    sel = 1;
    do_access(MEM_WRITE, 9'h0FF, 16'h1234);
    do_access(MEM_READ, 9'h0FF, 16'h0000);
    check("rd3_ready_cycle", ready_cyc - issue_cyc, 4);
    idle(3);
    check("rd3_data_held", r_read_data, 16'h1234);

    // MMIO.
    do_access(MEM_WRITE, 9'h100, 16'h12A5);
    check("led_value", r_led, 8'hA5);
    set_sw(8'h3C);
    do_access(MEM_READ, 9'h140, 16'h0000);
    check("sw_read", r_read_data, 16'h003C);
    idle(1);
    sw = 8'h99;
`ifndef MEM_BUS_CTRL_SW_SYNC_EN
    sw_model = 8'h99;
`endif
    step();
    do_access(MEM_READ, 9'h140, 16'h0000);
`ifdef MEM_BUS_CTRL_SW_SYNC_EN
    check("sw_late_change", r_read_data, 16'h003C);
`else
    check("sw_late_change", r_read_data, 16'h0099);
`endif
    set_sw(8'h99);

    // Errors.
    sel = 2;
    do_access(MEM_READ, 9'h1F0, 16'h0000);
    check("err_read_data", r_read_data, 16'h0000);
    check("err_bus_err", r_bus_err, 1'b1);
    idle(2);
    check("err_sticky", r_bus_err, 1'b1);
    sel = 0;
    do_access(MEM_RSVD, 9'h005, 16'h0000);
    idle(3);
    check("rsvd_bus_err", r_bus_err, 1'b1);

    // Reset mid-read on RD_LAT=4.
    sel = 2;
    mem_cmd = MEM_READ; mem_addr = 9'h020; write_data = '0;
    exp_re = 1'b1;
    step();
    exp_re = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_ready", r_ready, 1'b0);
    check("abort_ram_re", r_ram_re, 1'b0);
    step();
    mem_cmd = MEM_NONE;
    step();
    reset = 1'b1;
    idle(3);
    do_access(MEM_READ, 9'h020, 16'h0000);
    check("post_reset_ready_cycle", ready_cyc - issue_cyc, 5);
    check("post_reset_data", r_read_data, fill(8'h20));

    // Back-to-back reads held on RD_LAT=3.
    sel = 1;
    do_access(MEM_READ, 9'h010, 16'h0000);
    prev = ready_cyc;
    repeat (3) begin
      do_access(MEM_READ, 9'h010, 16'h0000);
      check("b2b_spacing", ready_cyc - prev, 5);
      prev = ready_cyc;
    end
    idle(1);

    // Randomized traffic across all lanes.
    for (int it = 0; it < 300; it++) begin
      logic [8:0] ua;
      sel = $urandom_range(0, N_LANE - 1);
      case ($urandom_range(0, 9))
        0, 1, 2: do_access(MEM_WRITE, {1'b0, 8'($urandom_range(0, 31))}, 16'($urandom));
        3, 4, 5: do_access(MEM_READ, {1'b0, 8'($urandom_range(0, 31))}, 16'($urandom));
        6:       do_access(MEM_WRITE, LED_ADDR_DEF, 16'($urandom));
        7:       do_access(MEM_READ, SW_ADDR_DEF, 16'($urandom));
        8: begin
          ua = {1'b1, 8'($urandom)};
          if ($urandom_range(0, 3) == 0) ua = ($urandom_range(0, 1) == 0) ? LED_ADDR_DEF : SW_ADDR_DEF;
          do_access(($urandom_range(0, 1) == 0) ? MEM_READ : MEM_WRITE, ua, 16'($urandom));
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_access(MEM_RSVD, 9'($urandom), 16'($urandom));
          else set_sw(8'($urandom));
        end
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
